// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter sharing one Mealy sequence detector among N_REQ serial requesters.
// Optional early-abort on dropped request is enabled by defining SEQ_DET_ARB_ABORT_EN.
module seq_det_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         bit_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     det_x,
  output logic                     det_rst,
  input  logic                     det_z,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     aborted
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, idx, idx_inc, arb_start, win_idx, pos_idx;
  logic [N_REQ-1:0] idx_oh, cand;
  logic            win_vld;
  logic [7:0]      bit_cnt;
  logic [CNT_W-1:0] match_q;
  logic            last_bit, abort_hit;
  int              pos;

  assign idx_oh    = N_REQ'(1) << idx;
  assign idx_inc   = (idx == IW'(N_REQ-1)) ? '0 : idx + IW'(1);
  assign last_bit  = (bit_cnt == 8'(FRAME_LEN-1));

  // In DONE the just-served requester still holds req, so it is masked out
  // and the search starts one past it (the pointer update lands at this edge).
  assign arb_start = (state == DONE) ? idx_inc : ptr;
  assign cand      = (state == DONE) ? (req & ~idx_oh) : req;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      pos = int'(arb_start) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = IW'(pos);
      if (cand[pos_idx]) begin
        win_vld = 1'b1;
        win_idx = pos_idx;
      end
    end
  end

`ifdef SEQ_DET_ARB_ABORT_EN
  logic aborted_q;

  assign abort_hit = ~req[idx];
  assign aborted   = aborted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else if (state == SETUP) begin
      aborted_q <= 1'b0;
    end else if (state == RUN && abort_hit && !last_bit) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
  assign aborted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SETUP;
      SETUP:   state_nxt = RUN;
      RUN:     if (last_bit || abort_hit) state_nxt = DONE;
      DONE:    state_nxt = win_vld ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      idx     <= '0;
      bit_cnt <= '0;
      match_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) idx <= win_idx;
        end
        SETUP: begin
          bit_cnt <= '0;
          match_q <= '0;
        end
        RUN: begin
          bit_cnt <= bit_cnt + 8'd1;
          if (det_z && (match_q != {CNT_W{1'b1}})) match_q <= match_q + CNT_W'(1);
        end
        DONE: begin
          ptr <= idx_inc;
          if (win_vld) idx <= win_idx;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt   = '0;
    det_x = 1'b0;
    done  = 1'b0;
    case (state)
      RUN: begin
        gnt   = idx_oh;
        det_x = bit_in[idx];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign det_rst   = reset | (state == SETUP);
  assign done_id   = idx;
  assign match_cnt = match_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: N_REQ=4, FRAME_LEN=16, CNT_W=3; the bench plays the detector.
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] gnt;
  logic       det_x;
  logic       det_rst;
  logic       det_z;
  logic       done;
  logic [1:0] done_id;
  logic [2:0] match_cnt;
  logic       aborted;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int last_done = -1;

  seq_det_arbiter #(.N_REQ(4), .FRAME_LEN(16), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .gnt(gnt),
    .det_x(det_x), .det_rst(det_rst), .det_z(det_z), .done(done),
    .done_id(done_id), .match_cnt(match_cnt), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (det_rst && !reset) rst_cnt <= rst_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the grant, stream 16 bits with det_z per zpat, optionally drop
  // req in RUN cycle drop_at, then check the DONE cycle.
  task automatic do_frame(input int id, input logic [15:0] zpat, input int exp_cnt,
                          input int drop_at, input bit chk_sp);
    int n;
    logic exp_ab;
    exp_ab = 1'b0;
    n = 0;
    while (gnt == 4'b0000 && n < 40) begin
      step();
      n++;
    end
    chk("gnt_onehot", gnt, 4'b0001 << id);
    for (int k = 1; k <= 16; k++) begin
      bit_in = 4'($urandom);
      det_z  = zpat[k-1];
      if (drop_at == k) req[id] = 1'b0;
      #1;
      chk("det_x_mux", det_x, bit_in[id]);
      chk("gnt_run", gnt, 4'b0001 << id);
      step();
`ifdef SEQ_DET_ARB_ABORT_EN
      if (drop_at == k) begin
        exp_ab = 1'b1;
        break;
      end
`endif
    end
    det_z = 1'b0;
    chk("done", done, 1'b1);
    chk("done_id", done_id, id);
    chk("match_cnt", match_cnt, exp_cnt);
    chk("aborted", aborted, exp_ab);
    if (chk_sp) chk("done_spacing", cyc - last_done, 18);
    last_done = cyc;
  endtask

  initial begin
    reset  = 1'b1;
    req    = 4'b0000;
    bit_in = 4'b0000;
    det_z  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_det_rst", det_rst, 1'b1);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_done", done, 1'b0);
    chk("rst_done_id", done_id, 2'd0);
    chk("rst_match_cnt", match_cnt, 3'd0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_det_x", det_x, 1'b0);
    reset = 1'b0;
    #1;
    chk("idle_det_rst", det_rst, 1'b0);

    // Single frame, matches in RUN cycles 3 and 9
    req = 4'b0001;
    step();
    chk("setup_det_rst", det_rst, 1'b1);
    chk("setup_gnt", gnt, 4'b0000);
    do_frame(0, 16'h0104, 2, 0, 1'b0);
    req = 4'b0000;
    step();
    chk("done_pulse_width", done, 1'b0);
    chk("idle_gnt", gnt, 4'b0000);

    // Round robin from a fresh pointer, then pointer wrap with req=1001
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    rst_cnt = 0;
    req = 4'b1111;
    do_frame(0, 16'h0000, 0, 0, 1'b0);
    do_frame(1, 16'h0001, 1, 0, 1'b1);
    do_frame(2, 16'h0003, 2, 0, 1'b1);
    do_frame(3, 16'h0007, 3, 0, 1'b1);
    chk("det_rst_per_frame", rst_cnt, 4);
    req = 4'b1001;
    do_frame(0, 16'h0000, 0, 0, 1'b1);
    do_frame(3, 16'h0000, 0, 0, 1'b1);
    req = 4'b0000;
    step();

    // Saturation (CNT_W=3) and match on the last bit
    req = 4'b0100;
    do_frame(2, 16'hFFFF, 7, 0, 1'b0);
    req = 4'b0000;
    step();
    req = 4'b0010;
    do_frame(1, 16'h8000, 1, 0, 1'b0);
    req = 4'b0000;
    step();
    chk("match_cnt_hold", match_cnt, 3'd1);

    // Reset in RUN cycle 5 of requester 2
    req = 4'b0100;
    do_frame_start: begin
      int n;
      n = 0;
      while (gnt == 4'b0000 && n < 40) begin
        step();
        n++;
      end
    end
    chk("mid_gnt", gnt, 4'b0100);
    step();
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_det_rst", det_rst, 1'b1);
    step();
    chk("mid_gnt_cleared", gnt, 4'b0000);
    chk("mid_no_done", done, 1'b0);
    reset = 1'b0;
    req = 4'b0101;
    do_frame(0, 16'h0000, 0, 0, 1'b0);
    req = 4'b0000;
    step();

    // Drop req[1] in RUN cycle 6, match in cycle 4
    req = 4'b0010;
    do_frame(1, 16'h0008, 1, 6, 1'b0);
    req = 4'b0000;
    step();
    chk("final_done_low", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin arbiter that shares one external Mealy non-overlapping sequence detector among N serial bit-stream requesters. Each granted requester streams a fixed-length frame through the detector. The arbiter resets the detector before every frame, counts the detector's match pulses over the frame, and reports a per-frame match count tagged with the requester index. It sits between the requester streams and the single detector instance, and owns the detector's `x` input and its reset.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `FRAME_LEN`, 16, bits per frame (2..255)
- `CNT_W`, 5, width of the match counter; saturates at 2^CNT_W-1
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `req`  input  N_REQ  per-requester frame request; level, held until `done` for that requester
- `bit_in`  input  N_REQ  per-requester serial data bit; sampled only while its `gnt` bit is high
- `gnt`  output  N_REQ  one-hot grant, high during RUN for the active requester
- `det_x`  output  1  serial bit to the detector
- `det_rst`  output  1  detector reset
- `det_z`  input  1  detector Mealy match output, same-cycle function of `det_x`
- `done`  output  1  one-cycle frame-complete pulse
- `done_id`  output  clog2(N_REQ)  requester index for `done`
- `match_cnt`  output  CNT_W  matches counted in the finished frame
- `aborted`  output  1  qualifies `done`: frame ended early

## Operation
- States are IDLE, SETUP, RUN and DONE.
- **IDLE:**
  - If any `req` bit is high, latch the winner into `idx` and go to SETUP.
  - The winner is the first set bit searching upward from `ptr`, wrapping modulo N_REQ.
- **SETUP** (1 cycle):
  - `det_rst`=1, `gnt`=0.
  - Clear `bit_cnt` and `match_cnt`.
  - Go to RUN.
- **RUN** (FRAME_LEN cycles):
  - `gnt[idx]`=1.
  - `det_x` = `bit_in[idx]`, a combinational mux; `det_x`=0 in every other state.
  - On each edge, `bit_cnt`++.
  - If `det_z`=1, `match_cnt`++ (saturating).
  - When `bit_cnt` = FRAME_LEN-1 on an edge, go to DONE.
- **DONE** (1 cycle):
  - `done`=1, `done_id`=`idx`.
  - `match_cnt` holds its final value until the next SETUP.
  - `ptr` <= (`idx`+1) mod N_REQ.
  - Next state: SETUP with a newly arbitrated winner if any `req` bit is high, else IDLE.
  - In this cycle `req[idx]` is still high and is excluded from arbitration, so the requester drops it after seeing `done`.
- **Arbitration:** the rotating pointer guarantees that no requester waits more than N_REQ-1 frames.
- **During RUN:** `req` changes from non-granted requesters are ignored until DONE.
- **`det_rst` source:** `det_rst` = `reset` OR (state==SETUP).

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `idx`=0, `gnt`=0, `det_x`=0, `det_rst`=1 (while `reset` is high), `done`=0, `done_id`=0, `match_cnt`=0, `aborted`=0.
- **Reset during RUN:** the frame is dropped with no `done` pulse, and the detector is reset in the same cycle.
- **Latency:** `req` rising in IDLE gives SETUP the next cycle, and `gnt` one cycle after that.
- **Frame length:** `done` follows exactly FRAME_LEN+2 cycles after leaving IDLE (SETUP + FRAME_LEN × RUN, then DONE).
- **Back-to-back frames:** DONE goes to SETUP directly, so the period is FRAME_LEN+2 cycles per frame.
- **Bit ordering:** the requester presents bit k in the k-th `gnt` cycle; the arbiter consumes it at the end of that cycle.
- **`det_z` sampling:** sampled in the same cycle as the `det_x` that caused it. A match on the last bit is counted.
- **Saturation:** `match_cnt` stops at 2^CNT_W-1.

## Configuration
- Macro `SEQ_DET_ARB_ABORT_EN`.
- **Defined:**
  - If `req[idx]` is sampled low on an edge during RUN, go to DONE next cycle with `aborted`=1.
  - `match_cnt` is the partial count, including any match in the cycle `req` was seen low.
- **Undefined:**
  - `req[idx]` is ignored during RUN and frames always run to FRAME_LEN.
  - `aborted` is tied to 0.

## Test plan
- **Reset and single frame:**
  - Stimulus: reset for 2 cycles, then `req`=0001 held; bench pulses `det_z` on RUN cycles 3 and 9.
  - Response: `det_rst` high during reset and SETUP; `gnt`=0001 for 16 cycles; `done` with `done_id`=0, `match_cnt`=2, `aborted`=0.
- **Round-robin fairness:**
  - Stimulus: `req`=1111 held continuously.
  - Response: `done_id` sequence is 0,1,2,3,0; `done` pulses are spaced 18 cycles apart; `det_rst` pulses once per frame.
- **Pointer wrap:**
  - Stimulus: after serving requester 3, `req`=1001.
  - Response: next grant is requester 0, then requester 3.
- **Saturation and last-bit match:**
  - Stimulus: `det_z` held at 1 for all 16 RUN cycles with CNT_W=3.
  - Response: `match_cnt`=7.
  - Stimulus: a single `det_z` pulse on RUN cycle 16.
  - Response: `match_cnt`=1.
- **Reset mid-frame:**
  - Stimulus: assert `reset` in RUN cycle 5 of requester 2's frame.
  - Response: no `done`; `gnt`=0 next cycle; `ptr`=0, so requester 0 is granted first after reset when `req`=0101.
- **Abort (`SEQ_DET_ARB_ABORT_EN` defined):**
  - Stimulus: drop `req[1]` in RUN cycle 6, with one `det_z` pulse in cycle 4.
  - Response: `done` one cycle later with `done_id`=1, `aborted`=1, `match_cnt`=1.
  - Without the macro the same stimulus runs the full 16 bits and leaves `aborted`=0.
